// File: rtl/top_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
package top_fifo_pkg;

    localparam int DATA_W        = 32;
    localparam int DEFAULT_DEPTH = 64;

    // Pointer width for a power-of-two depth (a depth of 2 still needs one bit).
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM with a synchronous write port and a registered read port.
module fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // The array is deliberately left without a reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // A same-edge write to the read address returns the old word (read-before-write).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/top_fifo.sv
// Single-clock synchronous FIFO: pointers, occupancy count, flags and error pulses around one RAM.
module top_fifo
    import top_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] data_write,
    output logic [DATA_W-1:0] data_read,
    output logic              full,
    output logic              empty,
    output logic [7:0]        status,
    output logic              err_read,
    output logic              err_write
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err_read;
    logic              r_err_write;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic [CNT_W-1:0]  w_count_next;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A write into a full FIFO is still taken when a read frees a slot on the same edge.
    assign w_wr_accept = write & (~w_full | read);
    assign w_rd_accept = read & ~w_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err_read  <= 1'b0;
            r_err_write <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count     <= w_count_next;
            r_err_read  <= read & w_empty;
            r_err_write <= write & w_full & ~read;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_write),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_read)
    );

    assign full      = w_full;
    assign empty     = w_empty;
    assign status    = 8'(r_count);
    assign err_read  = r_err_read;
    assign err_write = r_err_write;

endmodule

// File: tb/tb_top_fifo.sv
// Self-checking bench for top_fifo: fixed vectors, corner sequences and a queue-model random run.
module tb_top_fifo;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset;
    logic        write;
    logic        read;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        full;
    logic        empty;
    logic [7:0]  status;
    logic        err_read;
    logic        err_write;

    int checks;
    int failures;

    // Reference model state
    logic [31:0] model_q[$];
    logic [31:0] exp_data;
    logic        exp_err_r;
    logic        exp_err_w;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] d;
        logic [31:0] data;
        logic [7:0]  status;
        logic        full;
        logic        empty;
        logic        err_r;
        logic        err_w;
    } vec_t;

    vec_t vecs[9];

    top_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .read       (read),
        .data_write (data_write),
        .data_read  (data_read),
        .full       (full),
        .empty      (empty),
        .status     (status),
        .err_read   (err_read),
        .err_write  (err_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " data_read"}, data_read, exp_data);
        chk({tag, " status"}, 32'(status), 32'(model_q.size()));
        chk({tag, " full"}, 32'(full), 32'(model_q.size() == DEPTH));
        chk({tag, " empty"}, 32'(empty), 32'(model_q.size() == 0));
        chk({tag, " err_read"}, 32'(err_read), 32'(exp_err_r));
        chk({tag, " err_write"}, 32'(err_write), 32'(exp_err_w));
    endtask

    // Apply one clock of stimulus (called at a falling edge) and check the next falling edge.
    task automatic cycle(input logic w, input logic r, input logic [31:0] d, input string tag);
        bit was_full;
        bit was_empty;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        write = w;
        read = r;
        data_write = d;
        exp_err_w = w && was_full && !r;
        exp_err_r = r && was_empty;
        if (r && !was_empty) exp_data = model_q.pop_front();
        if (w && (!was_full || r)) model_q.push_back(d);
        @(negedge clk);
        $display("cyc %s w=%0b r=%0b d=%h -> data=%h status=%0d full=%0b empty=%0b er=%0b ew=%0b",
                 tag, w, r, d, data_read, status, full, empty, err_read, err_write);
        check_all(tag);
        write = 1'b0;
        read = 1'b0;
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_data = '0;
        exp_err_r = 1'b0;
        exp_err_w = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        write = 1'b0;
        read = 1'b0;
        data_write = '0;
        model_reset();

        //            w     r     d       data    status full  empty err_r err_w
        vecs[0] = '{1'b0, 1'b1, 32'd0,  32'd0,  8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'd11, 32'd0,  8'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'd22, 32'd0,  8'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd0,  32'd11, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'd33, 32'd22, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'd0,  32'd33, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'd44, 32'd33, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 32'd0,  32'd44, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 32'd0,  32'd44, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state before any clock edge
        #3;
        $display("reset: data=%h status=%0d full=%0b empty=%0b", data_read, status, full, empty);
        chk("reset data_read", data_read, 32'd0);
        chk("reset status", 32'(status), 32'd0);
        chk("reset full", 32'(full), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset err_read", 32'(err_read), 32'd0);
        chk("reset err_write", 32'(err_write), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fixed vectors with hand-computed expectations
        for (int i = 0; i < 9; i++) begin
            write = vecs[i].w;
            read = vecs[i].r;
            data_write = vecs[i].d;
            @(negedge clk);
            $display("vec %0d w=%0b r=%0b d=%h -> data=%h status=%0d er=%0b ew=%0b",
                     i, vecs[i].w, vecs[i].r, vecs[i].d, data_read, status, err_read, err_write);
            chk($sformatf("vec%0d data_read", i), data_read, vecs[i].data);
            chk($sformatf("vec%0d status", i), 32'(status), 32'(vecs[i].status));
            chk($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].full));
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].empty));
            chk($sformatf("vec%0d err_read", i), 32'(err_read), 32'(vecs[i].err_r));
            chk($sformatf("vec%0d err_write", i), 32'(err_write), 32'(vecs[i].err_w));
        end
        write = 1'b0;
        read = 1'b0;

        // Mid-run asynchronous reset: outputs must clear before the next rising edge
        model_reset();
        exp_data = 32'd44;
        cycle(1'b1, 1'b0, 32'h1234_5678, "pre-rst w");
        cycle(1'b1, 1'b1, 32'h9abc_def0, "pre-rst rw");
        cycle(1'b0, 1'b1, 32'h0, "pre-rst r");
        cycle(1'b1, 1'b0, 32'h5555_0000, "pre-rst w2");
        #1;
        reset = 1'b1;
        #1;
        $display("midrst: data=%h status=%0d full=%0b empty=%0b", data_read, status, full, empty);
        chk("midrst data_read", data_read, 32'd0);
        chk("midrst status", 32'(status), 32'd0);
        chk("midrst full", 32'(full), 32'd0);
        chk("midrst empty", 32'(empty), 32'd1);
        chk("midrst err_read", 32'(err_read), 32'd0);
        chk("midrst err_write", 32'(err_write), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Fill 1..64
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 32'(i), "fill");
        chk("fill full", 32'(full), 32'd1);
        chk("fill status", 32'(status), 32'd64);

        // Overflow for two cycles
        cycle(1'b1, 1'b0, 32'hDEAD_0001, "ovf1");
        chk("ovf1 err_write", 32'(err_write), 32'd1);
        cycle(1'b1, 1'b0, 32'hDEAD_0002, "ovf2");
        chk("ovf2 err_write", 32'(err_write), 32'd1);
        chk("ovf status", 32'(status), 32'd64);

        // Full + read + write: count holds, no error
        cycle(1'b1, 1'b1, 32'hA5A5_A5A5, "full rw");
        chk("full rw data_read", data_read, 32'd1);
        chk("full rw status", 32'(status), 32'd64);
        chk("full rw err_write", 32'(err_write), 32'd0);

        // Drain: 2..64 then the simultaneous-write word
        for (int i = 2; i <= DEPTH; i++) begin
            cycle(1'b0, 1'b1, 32'h0, "drain");
            chk("drain order", data_read, 32'(i));
        end
        cycle(1'b0, 1'b1, 32'h0, "drain last");
        chk("drain last word", data_read, 32'hA5A5_A5A5);
        chk("drain empty", 32'(empty), 32'd1);

        // Underflow: single pulse, data_read holds
        cycle(1'b0, 1'b1, 32'h0, "udf");
        chk("udf err_read", 32'(err_read), 32'd1);
        chk("udf data_read", data_read, 32'hA5A5_A5A5);
        cycle(1'b0, 1'b0, 32'h0, "udf after");
        chk("udf pulse end", 32'(err_read), 32'd0);

        // Empty + read + write: write taken, read rejected
        cycle(1'b1, 1'b1, 32'hCAFE_0001, "empty rw");
        chk("empty rw err_read", 32'(err_read), 32'd1);
        chk("empty rw status", 32'(status), 32'd1);
        chk("empty rw data_read", data_read, 32'hA5A5_A5A5);

        // Randomised interleaving: write-heavy, then read-heavy, then balanced
        for (int i = 0; i < 200; i++) begin
            int wp;
            int rp;
            if (i < 80) begin
                wp = 85; rp = 30;
            end else if (i < 150) begin
                wp = 25; rp = 85;
            end else begin
                wp = 55; rp = 55;
            end
            cycle(logic'($urandom_range(99) < wp), logic'($urandom_range(99) < rp), $urandom, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
